// File: rtl/axi_mem_pkg.sv
// Shared types, response codes and address decode helpers for the AXI4-Lite memory responder.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // Operands are widened to 64 bits so any ADDR_WIDTH up to 64 decodes without wraparound.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input logic [63:0] depth);
    return (addr >= base) && (((addr - base) >> 2) < depth);
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word RAM: byte-enabled bus write, full-word backdoor write, bus read port and backdoor read port.
module axi_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_bus_we,
  input  logic [IDX_W-1:0] i_bus_widx,
  input  logic [31:0]      i_bus_wdata,
  input  logic [3:0]       i_bus_be,
  input  logic [IDX_W-1:0] i_a_idx,
  output logic [31:0]      o_a_rdata,
  input  logic             i_bd_we,
  input  logic [IDX_W-1:0] i_bd_idx,
  input  logic [31:0]      i_bd_wdata,
  output logic [31:0]      o_bd_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_bd_blocked;

  // A bus commit to the same word suppresses the whole backdoor write.
  assign w_bd_blocked = i_bus_we && (i_bus_widx == i_bd_idx);

  always_ff @(posedge clk) begin
    if (i_bd_we && !w_bd_blocked) r_mem[i_bd_idx] <= i_bd_wdata;
    if (i_bus_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_bus_be[b]) r_mem[i_bus_widx][8*b +: 8] <= i_bus_wdata[8*b +: 8];
      end
    end
  end

  assign o_a_rdata  = r_mem[i_a_idx];
  assign o_bd_rdata = r_mem[i_bd_idx];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-Lite single-beat memory target with independent read and write FSMs and a backdoor port.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic                           bd_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr,
  input  logic [31:0]                    bd_wdata,
  output logic [31:0]                    bd_rdata,
  output logic                           o_dbg_w_state,
  output logic [1:0]                     o_dbg_r_state
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  // Handshakes: a beat transfers on a rising edge where valid && ready; a raised valid
  // (BVALID/RVALID) holds with stable payload until that edge, and each ready is low while busy.
  w_state_e         r_wstate;
  r_state_e         r_rstate;
  logic             r_awready, r_wready, r_arready;
  logic             r_aw_held, r_w_held, r_aw_ok, r_ar_ok;
  logic [IDX_W-1:0] r_aw_idx, r_ar_idx;
  logic [31:0]      r_wdata, r_rdata;
  logic [3:0]       r_wstrb, r_cnt;
  logic             r_bvalid, r_rvalid;
  logic [1:0]       r_bresp, r_rresp;

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_aw_ok, w_ar_ok, w_rd_ok, w_bus_we;
  logic [IDX_W-1:0] w_aw_idx, w_ar_idx, w_rd_idx;
  logic [31:0]      w_rd_data, w_rd_sample;
  logic [1:0]       w_rd_resp;

  assign w_aw_hs  = S_AXI_AWVALID && r_awready;
  assign w_w_hs   = S_AXI_WVALID && r_wready;
  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_aw_ok  = addr_in_range(64'(S_AXI_AWADDR), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
  assign w_ar_ok  = addr_in_range(64'(S_AXI_ARADDR), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
  assign w_aw_idx = IDX_W'(word_index(64'(S_AXI_AWADDR), 64'(BASE_ADDR)));
  assign w_ar_idx = IDX_W'(word_index(64'(S_AXI_ARADDR), 64'(BASE_ADDR)));

  // In R_IDLE the live AR address feeds the RAM so READ_LATENCY=1 can sample on the handshake edge.
  assign w_rd_idx    = (r_rstate == R_IDLE) ? w_ar_idx : r_ar_idx;
  assign w_rd_ok     = (r_rstate == R_IDLE) ? w_ar_ok : r_ar_ok;
  assign w_rd_sample = w_rd_ok ? w_rd_data : 32'h0;
  assign w_rd_resp   = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
  assign w_bus_we    = (r_wstate == W_IDLE) && r_aw_held && r_w_held && r_aw_ok;

  axi_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk        (S_AXI_ACLK),
    .i_bus_we   (w_bus_we),
    .i_bus_widx (r_aw_idx),
    .i_bus_wdata(r_wdata),
    .i_bus_be   (r_wstrb),
    .i_a_idx    (w_rd_idx),
    .o_a_rdata  (w_rd_data),
    .i_bd_we    (bd_we),
    .i_bd_idx   (bd_addr),
    .i_bd_wdata (bd_wdata),
    .o_bd_rdata (bd_rdata)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_ok   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_ok   <= w_aw_ok;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA[31:0];
            r_wstrb  <= S_AXI_WSTRB[3:0];
          end
          r_awready <= !(w_aw_hs || r_aw_held);
          r_wready  <= !(w_w_hs || r_w_held);
          if (r_aw_held && r_w_held) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= r_aw_ok ? RESP_OKAY : RESP_SLVERR;
            r_wstate  <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_ar_idx  <= '0;
      r_ar_ok   <= 1'b0;
      r_cnt     <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= !w_ar_hs;
          if (w_ar_hs) begin
            r_ar_idx <= w_ar_idx;
            r_ar_ok  <= w_ar_ok;
            r_cnt    <= LAT_M1;
            if (READ_LATENCY == 1) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_rd_sample;
              r_rresp  <= w_rd_resp;
              r_rstate <= R_DATA;
            end else begin
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_sample;
            r_rresp  <= w_rd_resp;
            r_rstate <= R_DATA;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = DATA_WIDTH'(r_rdata);
  assign S_AXI_RRESP   = r_rresp;
  assign o_dbg_w_state = r_wstate;
  assign o_dbg_r_state = r_rstate;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: backdoor preload, bus reads/writes, stalls, decode errors, collisions, reset.
module tb_axi_mem_responder;

  localparam int DEPTH = 64;

  logic        aclk, aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata, bd_wdata, bd_rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, bd_we;
  logic [1:0]  bresp, rresp, dbg_r_state;
  logic        dbg_w_state;
  logic [5:0]  bd_addr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] exp_q[$];

  axi_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(32'h0), .READ_LATENCY(3)
  ) dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .o_dbg_w_state(dbg_w_state), .o_dbg_r_state(dbg_r_state)
  );

  // Clock and watchdog
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    bd_we = 1'b1; bd_addr = 6'(idx); bd_wdata = data;
    tick();
    bd_we = 1'b0;
    exp_mem[idx] = data;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bd_addr = 6'(i);
      #1;
      check($sformatf("%s_w%0d", tag, i), bd_rdata, exp_mem[i]);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp_data);
    araddr = addr; arvalid = 1'b1;
    lat = 0;
    while (!arready && lat < 20) begin tick(); lat++; end
    check({tag, "_arready"}, 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!rvalid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rdata, e);
    check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    check({tag, "_arready_back"}, 32'(arready), 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input string tag);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  // Directed sequence
  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    tick(); tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    tick();
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    for (int i = 0; i < DEPTH; i++) bd_write(i, 32'h0);
    bd_write(0, 32'd1); bd_write(1, 32'd2); bd_write(2, 32'd3); bd_write(3, 32'd4);
    bd_write(8, 32'h11);

    do_read(32'h0, 32'd1, 2'b00, "rd0");
    do_read(32'h4, 32'd2, 2'b00, "rd1");
    do_read(32'h8, 32'd3, 2'b00, "rd2");
    do_read(32'hC, 32'd4, 2'b00, "rd3");

    // W beat one cycle ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready_drop", 32'(wready), 32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wfirst_bvalid_drop", 32'(bvalid), 32'd0);
    check("wfirst_awready_back", 32'(awready), 32'd1);
    check("wfirst_wready_back", 32'(wready), 32'd1);
    exp_mem[4] = 32'h00AD00EF;
    bd_addr = 6'd4;
    #1;
    check("wfirst_mem4", bd_rdata, exp_mem[4]);

    // Concurrent write and read, both responses stalled
    awaddr = 32'h14; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int k = 0; k < 20 && !rvalid; k++) tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_bvalid", 32'(bvalid), 32'd1);
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_bresp", 32'(bresp), 32'd0);
      check("stall_rresp", 32'(rresp), 32'd0);
      check("stall_rdata", rdata, 32'd2);
      check("stall_arready", 32'(arready), 32'd0);
      check("stall_awready", 32'(awready), 32'd0);
      check("stall_wready", 32'(wready), 32'd0);
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("stall_bvalid_drop", 32'(bvalid), 32'd0);
    check("stall_rvalid_drop", 32'(rvalid), 32'd0);
    check("stall_arready_back", 32'(arready), 32'd1);
    check("stall_awready_back", 32'(awready), 32'd1);
    check("stall_wready_back", 32'(wready), 32'd1);
    exp_mem[5] = 32'hCAFEF00D;

    // Out-of-range at DEPTH*4 bytes
    do_read(32'h100, 32'd0, 2'b10, "oor_rd");
    bus_write(32'h100, 32'hFFFFFFFF, 4'hF, 2'b10, "oor_wr");
    check_mem("oor_mem");

    // Read sample and bus commit to word 8 on the same edge
    araddr = 32'h20; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("coll_arready_drop", 32'(arready), 32'd0);
    tick();
    awaddr = 32'h20; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_bvalid", 32'(bvalid), 32'd1);
    check("coll_rdata_old", rdata, 32'h11);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    exp_mem[8] = 32'h22;
    do_read(32'h20, 32'h22, 2'b00, "coll_rd_new");

    // Reset with a stalled read and a lone AW
    araddr = 32'h8; arvalid = 1'b1; awaddr = 32'hC; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    tick(); tick(); tick();
    check("mid_rvalid", 32'(rvalid), 32'd1);
    check("mid_awready", 32'(awready), 32'd0);
    check("mid_wready", 32'(wready), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_wstate", 32'(dbg_w_state), 32'd0);
    check("mid_rst_rstate", 32'(dbg_r_state), 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    check("mid_rel_awready", 32'(awready), 32'd1);
    check("mid_rel_wready", 32'(wready), 32'd1);
    check("mid_rel_arready", 32'(arready), 32'd1);
    bd_addr = 6'd3;
    #1;
    check("mid_mem3", bd_rdata, 32'd4);
    do_read(32'hC, 32'd4, 2'b00, "mid_rd");

    // A lone W after reset must wait for a fresh AW
    wdata = 32'h0BAD0BAD; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    check("post_rst_no_commit", 32'(bvalid), 32'd0);
    awaddr = 32'h24; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    check("post_rst_bvalid", 32'(bvalid), 32'd1);
    check("post_rst_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    exp_mem[9] = 32'h0BAD0BAD;
    check_mem("final_mem");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
